// File: rtl/data_mem_responder.sv
// Data-side responder: word RAM, GPIO_OUT register and a compare timer with interrupt flag.
// Reads are combinational with zero latency; writes commit on the clock edge; there is no backpressure.
module data_mem_responder #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            mem_we_i,
    input  logic [XLEN-1:0] mem_addr_i,
    input  logic [XLEN-1:0] mem_data_i,
    output logic [XLEN-1:0] mem_data_o,
    output logic [XLEN-1:0] gpio_o,
    output logic            irq_o
);

    localparam logic [2:0] IO_GPIO   = 3'd0;
    localparam logic [2:0] IO_CNT    = 3'd1;
    localparam logic [2:0] IO_CMP    = 3'd2;
    localparam logic [2:0] IO_CTRL   = 3'd3;
    localparam logic [2:0] IO_STATUS = 3'd4;

    logic [XLEN-1:0] ram [DEPTH_WORDS];

    logic [XLEN-1:0] gpio_q;
    logic [XLEN-1:0] cnt_q;
    logic [XLEN-1:0] cmp_q;
    logic            ten_q;
    logic            irq_en_q;
    logic            pend_q;

    logic            is_io;
    logic [2:0]      io_sel;
    logic [AW-1:0]   ram_idx;
    logic            ram_we;
    logic            io_we;
    logic            wr_gpio;
    logic            wr_cnt;
    logic            wr_cmp;
    logic            wr_ctrl;
    logic            wr_status;
    logic            timer_match;
    logic            unused_addr_bits;

    assign is_io   = mem_addr_i[XLEN-1];
    assign io_sel  = mem_addr_i[4:2];
    assign ram_idx = mem_addr_i[AW+1:2];
    assign ram_we  = mem_we_i & ~is_io;
    assign io_we   = mem_we_i & is_io;

    assign wr_gpio   = io_we && (io_sel == IO_GPIO);
    assign wr_cnt    = io_we && (io_sel == IO_CNT);
    assign wr_cmp    = io_we && (io_sel == IO_CMP);
    assign wr_ctrl   = io_we && (io_sel == IO_CTRL);
    assign wr_status = io_we && (io_sel == IO_STATUS);

    // Compare uses pre-edge CNT/CMP, so a same-edge CMP write cannot mask a match.
    assign timer_match = ten_q && (cnt_q == cmp_q);

    // Byte-offset bits and the aliasing upper address bits take no part in decode.
    assign unused_addr_bits = ^{mem_addr_i[XLEN-2:AW+2], mem_addr_i[1:0]};

    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            ram[ram_idx] <= mem_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gpio_q   <= '0;
            cnt_q    <= '0;
            cmp_q    <= '1;
            ten_q    <= 1'b0;
            irq_en_q <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            if (wr_gpio) begin
                gpio_q <= mem_data_i;
            end
            if (wr_cnt) begin
                cnt_q <= mem_data_i;
            end else if (ten_q) begin
                cnt_q <= cnt_q + XLEN'(1);
            end
            if (wr_cmp) begin
                cmp_q <= mem_data_i;
            end
            if (wr_ctrl) begin
                ten_q    <= mem_data_i[0];
                irq_en_q <= mem_data_i[1];
            end
            // A fresh match outranks a same-edge W1C.
            if (timer_match) begin
                pend_q <= 1'b1;
            end else if (wr_status && mem_data_i[0]) begin
                pend_q <= 1'b0;
            end
        end
    end

    always_comb begin
        mem_data_o = '0;
        if (!is_io) begin
            mem_data_o = ram[ram_idx];
        end else begin
            case (io_sel)
                IO_GPIO:   mem_data_o = gpio_q;
                IO_CNT:    mem_data_o = cnt_q;
                IO_CMP:    mem_data_o = cmp_q;
                IO_CTRL:   mem_data_o = {{(XLEN-2){1'b0}}, irq_en_q, ten_q};
                IO_STATUS: mem_data_o = {{(XLEN-1){1'b0}}, pend_q};
                default:   mem_data_o = '0;
            endcase
        end
    end

    assign gpio_o = gpio_q;
    assign irq_o  = pend_q & irq_en_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: register-level model checked every cycle plus directed literal checks.
module tb_data_mem_responder;

    localparam int XLEN  = 32;
    localparam int DEPTH = 256;

    localparam logic [31:0] A_GPIO   = 32'h8000_0000;
    localparam logic [31:0] A_CNT    = 32'h8000_0004;
    localparam logic [31:0] A_CMP    = 32'h8000_0008;
    localparam logic [31:0] A_CTRL   = 32'h8000_000C;
    localparam logic [31:0] A_STATUS = 32'h8000_0010;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic [31:0] gpio;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    data_mem_responder #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH), .AW(8)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .mem_we_i   (we),
        .mem_addr_i (addr),
        .mem_data_i (wdata),
        .mem_data_o (rdata),
        .gpio_o     (gpio),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Register-level model of the memory map, updated once per edge from the presented access.
    logic [31:0] m_ram [DEPTH];
    bit          m_vld [DEPTH];
    logic [31:0] m_gpio, m_cnt, m_cmp;
    bit          m_ten, m_ien, m_pend;
    bit          m_hit;
    logic [31:0] exp_rd;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_gpio = 32'h0;
            m_cnt  = 32'h0;
            m_cmp  = 32'hFFFF_FFFF;
            m_ten  = 1'b0;
            m_ien  = 1'b0;
            m_pend = 1'b0;
        end else begin
            m_hit = m_ten && (m_cnt == m_cmp);
            if (m_ten) m_cnt = m_cnt + 32'd1;
            if (we) begin
                if (!addr[31]) begin
                    m_ram[addr[9:2]] = wdata;
                    m_vld[addr[9:2]] = 1'b1;
                end else begin
                    case (addr[4:2])
                        3'd0: m_gpio = wdata;
                        3'd1: m_cnt  = wdata;
                        3'd2: m_cmp  = wdata;
                        3'd3: begin m_ten = wdata[0]; m_ien = wdata[1]; end
                        3'd4: if (wdata[0]) m_pend = 1'b0;
                        default: ;
                    endcase
                end
            end
            if (m_hit) m_pend = 1'b1;
        end
    end

    function automatic bit m_read(input logic [31:0] a, output logic [31:0] d);
        d = 32'h0;
        if (!a[31]) begin
            d = m_ram[a[9:2]];
            return m_vld[a[9:2]];
        end
        case (a[4:2])
            3'd0: d = m_gpio;
            3'd1: d = m_cnt;
            3'd2: d = m_cmp;
            3'd3: d = {30'h0, m_ien, m_ten};
            3'd4: d = {31'h0, m_pend};
            default: d = 32'h0;
        endcase
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (m_read(addr, exp_rd)) chk("model_rdata", rdata, exp_rd);
            chk("model_gpio", gpio, m_gpio);
            chk("model_irq", {31'h0, irq}, {31'h0, m_pend & m_ien});
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        we = 1'b1;
        addr = a;
        wdata = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    initial begin
        logic [31:0] d;
        int waited;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_gpio", gpio, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        rd(A_CNT, d);    chk("rst_cnt", d, 32'h0);
        rd(A_CMP, d);    chk("rst_cmp", d, 32'hFFFF_FFFF);
        rd(A_CTRL, d);   chk("rst_ctrl", d, 32'h0);
        rd(A_STATUS, d); chk("rst_status", d, 32'h0);

        // RAM write, read back, alias and ignored byte offset
        wr(32'h10, 32'hDEAD_BEEF);
        rd(32'h10, d);  chk("ram_read", d, 32'hDEAD_BEEF);
        rd(32'h410, d); chk("ram_alias", d, 32'hDEAD_BEEF);
        rd(32'h13, d);  chk("ram_byteoff", d, 32'hDEAD_BEEF);

        // Same-cycle read-during-write returns the old word
        wr(32'h20, 32'd3);
        we = 1'b1; addr = 32'h20; wdata = 32'd5;
        #1;
        chk("rw_old", rdata, 32'd3);
        @(posedge clk);
        #1;
        we = 1'b0;
        chk("rw_new", rdata, 32'd5);

        // Timer match: PEND rises on the edge where pre-edge CNT equals CMP
        wr(A_CMP, 32'd10);
        wr(A_CNT, 32'd0);
        wr(A_CTRL, 32'd3);
        chk("tmr_irq_low", {31'h0, irq}, 32'h0);
        waited = 0;
        while (!irq && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("tmr_irq_edges", waited, 32'd11);
        rd(A_CNT, d); chk("tmr_cnt_at_irq", d, 32'd11);
        wr(A_STATUS, 32'd1);
        chk("tmr_w1c_irq", {31'h0, irq}, 32'h0);
        rd(A_STATUS, d); chk("tmr_w1c_status", d, 32'h0);

        // Wrap, CNT write priority, collisions
        wr(A_CNT, 32'hFFFF_FFFF);
        rd(A_CNT, d); chk("wrap_pre", d, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        rd(A_CNT, d); chk("wrap_zero", d, 32'h0);
        wr(A_CNT, 32'd7);
        rd(A_CNT, d); chk("cnt_write_wins", d, 32'd7);
        wr(A_CMP, 32'd52);
        wr(A_CNT, 32'd52);
        wr(A_STATUS, 32'd1);
        chk("w1c_vs_match_irq", {31'h0, irq}, 32'h1);
        rd(A_STATUS, d); chk("w1c_vs_match_pend", d, 32'h1);
        wr(A_STATUS, 32'd0);
        chk("status_w0_noop", {31'h0, irq}, 32'h1);
        wr(A_STATUS, 32'd1);
        chk("status_clear", {31'h0, irq}, 32'h0);
        wr(A_CNT, 32'd52);
        wr(A_CMP, 32'h1000);
        chk("cmp_write_old_match", {31'h0, irq}, 32'h1);
        rd(A_CMP, d); chk("cmp_new_value", d, 32'h1000);
        wr(A_CTRL, 32'd1);
        chk("irq_masked", {31'h0, irq}, 32'h0);
        rd(A_STATUS, d); chk("pend_kept_masked", d, 32'h1);
        wr(A_CTRL, 32'd3);
        chk("irq_unmasked", {31'h0, irq}, 32'h1);

        // Asynchronous reset between edges
        wr(A_GPIO, 32'hA5);
        wr(A_CNT, 32'd50);
        rd(A_CNT, d); chk("pre_rst_cnt", d, 32'd50);
        chk("pre_rst_gpio", gpio, 32'hA5);
        rst = 1'b1;
        #1;
        chk("async_rst_cnt", rdata, 32'h0);
        chk("async_rst_gpio", gpio, 32'h0);
        chk("async_rst_irq", {31'h0, irq}, 32'h0);
        rd(A_CMP, d); chk("async_rst_cmp", d, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // IO holes and decode aliasing; RAM survives reset
        rd(32'h10, d); chk("ram_after_rst", d, 32'hDEAD_BEEF);
        wr(A_GPIO, 32'h5A);
        wr(32'h8000_0018, 32'h1234);
        rd(32'h8000_0018, d); chk("hole_reads_zero", d, 32'h0);
        chk("hole_gpio_kept", gpio, 32'h5A);
        rd(A_CMP, d); chk("hole_cmp_kept", d, 32'hFFFF_FFFF);
        rd(A_CNT, d); chk("hole_cnt_kept", d, 32'h0);
        rd(32'hC000_0000, d); chk("io_alias_gpio", d, 32'h5A);

        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
